// File: rtl/ab_feeder_pkg.sv
// Shared constants and state encoding for the ab_feeder operand source / result sink.
package ab_feeder_pkg;

  localparam int OP_W      = 8;
  localparam int RES_W     = 16;
  localparam int MEM_DEPTH = 8;
  localparam int IDX_W     = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STRT    = 3'd1,
    FEED    = 3'd2,
    WAIT_X  = 3'd3,
    COLLECT = 3'd4,
    HLT     = 3'd5
  } state_t;

endpackage

// File: rtl/ab_feeder_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seeded to 8'hA5; Q is the low bit.
module ab_feeder_lfsr (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  output logic Q
);

  logic [7:0] r_q;
  logic       w_fb;

  assign w_fb = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];
  assign Q    = r_q[0];

  always_ff @(posedge CLK) begin
    if (RST)     r_q <= 8'hA5;
    else if (EN) r_q <= {r_q[6:0], w_fb};
  end

endmodule

// File: rtl/ab_feeder.sv
// Host-side feeder: serves A/B pairs on REQ_AB/ACK and captures X results.
// Define FEEDER_RAND_STALL_EN to OR a pseudo-random stall bit into STALL.
module ab_feeder
  import ab_feeder_pkg::*;
#(
  parameter int NUM_PAIRS   = 8,
  parameter int NUM_RESULTS = 8,
  parameter int TIMEOUT     = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [2:0]        WR_ADDR,
  input  logic [OP_W-1:0]   WR_A,
  input  logic [OP_W-1:0]   WR_B,
  input  logic              GO,
  input  logic              ABORT,
  input  logic              STALL,
  input  logic              REQ_AB,
  output logic [OP_W-1:0]   A,
  output logic [OP_W-1:0]   B,
  output logic              ACK,
  output logic              START,
  output logic              HALT,
  input  logic [RES_W-1:0]  X,
  input  logic              X_VALID,
  input  logic [2:0]        RD_ADDR,
  output logic [RES_W-1:0]  RD_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  localparam int CNT_W = IDX_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] NP      = CNT_W'(NUM_PAIRS);
  localparam logic [CNT_W-1:0] NR      = CNT_W'(NUM_RESULTS);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT - 1);

  state_t r_state, w_next;
  logic [OP_W-1:0]  r_memA [MEM_DEPTH];
  logic [OP_W-1:0]  r_memB [MEM_DEPTH];
  logic [RES_W-1:0] r_res  [MEM_DEPTH];
  logic [CNT_W-1:0] r_pairIdx, r_resIdx;
  logic [TMO_W-1:0] r_tmo;
  logic r_done, r_err;
  logic w_stall, w_active, w_ack, w_cap, w_lastPair, w_lastRes, w_idleCyc, w_timeout;

`ifdef FEEDER_RAND_STALL_EN
  logic w_lfsrBit;
  ab_feeder_lfsr u_lfsr (.CLK(CLK), .RST(RST), .EN(1'b1), .Q(w_lfsrBit));
  assign w_stall = STALL | w_lfsrBit;
`else
  assign w_stall = STALL;
`endif

  assign A       = r_memA[r_pairIdx[IDX_W-1:0]];
  assign B       = r_memB[r_pairIdx[IDX_W-1:0]];
  assign RD_DATA = r_res[RD_ADDR];
  assign DONE    = r_done;
  assign ERR     = r_err;

  // Results are accepted in every run phase after START so overlapped output is never lost.
  assign w_active   = (r_state == FEED) || (r_state == WAIT_X) || (r_state == COLLECT);
  assign w_ack      = (r_state == FEED) && REQ_AB && !w_stall && (r_pairIdx < NP);
  assign w_cap      = w_active && X_VALID && (r_resIdx < NR);
  assign w_lastPair = w_ack && (r_pairIdx == NP - CNT_W'(1));
  assign w_lastRes  = w_cap && (r_resIdx == NR - CNT_W'(1));
  assign w_idleCyc  = w_active && !w_ack && !w_cap;
  assign w_timeout  = w_idleCyc && (r_tmo == TMO_MAX);

  always_comb begin
    w_next = r_state;
    ACK    = w_ack;
    START  = (r_state == STRT);
    HALT   = (r_state == HLT);
    BUSY   = (r_state != IDLE);
    case (r_state)
      IDLE:    if (GO) w_next = STRT;
      STRT:    w_next = ABORT ? HLT : FEED;
      FEED, WAIT_X, COLLECT: begin
        if (ABORT || w_timeout)      w_next = HLT;
        else if (w_lastRes)          w_next = IDLE;
        else if (r_state == FEED) begin
          if (w_lastPair) w_next = (w_cap || (r_resIdx != '0)) ? COLLECT : WAIT_X;
        end
        else if ((r_state == WAIT_X) && w_cap) w_next = COLLECT;
      end
      HLT:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_pairIdx <= '0;
      r_resIdx  <= '0;
      r_tmo     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && GO) begin
        r_pairIdx <= '0;
        r_resIdx  <= '0;
        r_tmo     <= '0;
        r_done    <= 1'b0;
        r_err     <= 1'b0;
      end else begin
        if (w_ack) r_pairIdx <= r_pairIdx + CNT_W'(1);
        if (w_cap) r_resIdx  <= r_resIdx + CNT_W'(1);
        if (w_ack || w_cap)  r_tmo <= '0;
        else if (w_idleCyc)  r_tmo <= r_tmo + TMO_W'(1);
        if (w_next == HLT)   r_err <= 1'b1;
        if (w_lastRes && (w_next == IDLE)) r_done <= 1'b1;
      end
    end
  end

  // Memories survive reset so results from an aborted or reset run stay readable.
  always_ff @(posedge CLK) begin
    if (WR_EN) begin
      r_memA[WR_ADDR] <= WR_A;
      r_memB[WR_ADDR] <= WR_B;
    end
    if (w_cap && !RST) r_res[r_resIdx[IDX_W-1:0]] <= X;
  end

endmodule

// File: tb/tb_ab_feeder.sv
// Self-checking bench for ab_feeder: run-level reference model plus directed scenarios.
module tb_ab_feeder;

  localparam int NP = 8;
  localparam int NR = 8;
  localparam int TO = 64;

  logic        CLK = 1'b0, RST = 1'b1;
  logic        WR_EN = 1'b0;
  logic [2:0]  WR_ADDR = '0, RD_ADDR = '0;
  logic [7:0]  WR_A = '0, WR_B = '0, A, B;
  logic        GO = 1'b0, ABORT = 1'b0, STALL = 1'b0, REQ_AB = 1'b0, X_VALID = 1'b0;
  logic [15:0] X = '0, RD_DATA;
  logic        ACK, START, HALT, BUSY, DONE, ERR;

  int checks = 0, failures = 0;

  ab_feeder #(.NUM_PAIRS(NP), .NUM_RESULTS(NR), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_A(WR_A), .WR_B(WR_B),
    .GO(GO), .ABORT(ABORT), .STALL(STALL), .REQ_AB(REQ_AB), .A(A), .B(B), .ACK(ACK),
    .START(START), .HALT(HALT), .X(X), .X_VALID(X_VALID), .RD_ADDR(RD_ADDR),
    .RD_DATA(RD_DATA), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Run-level model: phase 0 idle, 1 start pulse, 2 running, 3 halt pulse.
  int          mPhase = 0, mFed = 0, mGot = 0, mIdle = 0;
  bit          mDone = 0, mErr = 0, mValid = 0, mXf, mCp;
  logic [15:0] mOp  [8];
  logic [15:0] mRes [8];
  bit          mResV [8];
  logic [7:0]  mLfsr = 8'hA5;

  function automatic bit stallNow();
`ifdef FEEDER_RAND_STALL_EN
    return STALL | mLfsr[0];
`else
    return STALL;
`endif
  endfunction

  function automatic bit expAck();
    return (mPhase == 2) && REQ_AB && !stallNow() && (mFed < NP);
  endfunction

  always @(posedge CLK) begin
    if (WR_EN) mOp[WR_ADDR] = {WR_A, WR_B};
    if (RST) begin
      mValid = 1; mPhase = 0; mFed = 0; mGot = 0; mIdle = 0; mDone = 0; mErr = 0;
    end else begin
      case (mPhase)
        0: if (GO) begin
             mPhase = 1; mFed = 0; mGot = 0; mIdle = 0; mDone = 0; mErr = 0;
           end
        1: begin
             mPhase = ABORT ? 3 : 2;
             if (ABORT) mErr = 1;
           end
        2: begin
             mXf = expAck();
             mCp = X_VALID && (mGot < NR);
             if (mXf) mFed++;
             if (mCp) begin mRes[mGot] = X; mResV[mGot] = 1; mGot++; end
             if (mXf || mCp) mIdle = 0; else mIdle++;
             if (ABORT || mIdle == TO) begin mPhase = 3; mErr = 1; end
             else if (mCp && mGot == NR) begin mPhase = 0; mDone = 1; end
           end
        default: mPhase = 0;
      endcase
    end
    if (RST) mLfsr = 8'hA5;
    else     mLfsr = {mLfsr[6:0], mLfsr[7] ^ mLfsr[5] ^ mLfsr[4] ^ mLfsr[3]};
  end

  always @(negedge CLK) begin
    if (mValid) begin
      checkOutput("BUSY", BUSY, 32'(mPhase != 0));
      checkOutput("START", START, 32'(mPhase == 1));
      checkOutput("HALT", HALT, 32'(mPhase == 3));
      checkOutput("DONE", DONE, 32'(mDone));
      checkOutput("ERR", ERR, 32'(mErr));
      checkOutput("ACK", ACK, 32'(expAck()));
      if (expAck()) begin
        checkOutput("A", A, 32'(mOp[mFed][15:8]));
        checkOutput("B", B, 32'(mOp[mFed][7:0]));
      end
      if (mResV[RD_ADDR]) checkOutput("RD_DATA", RD_DATA, 32'(mRes[RD_ADDR]));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < 8; i++) begin
      WR_EN = 1; WR_ADDR = 3'(i); WR_A = 8'd1; WR_B = 8'(i + 1);
      tick();
    end
    WR_EN = 0;
  endtask

  task automatic launch();
    GO = 1; tick(); GO = 0;
    checkOutput("startPulse", START, 1);
    tick();
    checkOutput("startOnce", START, 0);
  endtask

  task automatic feedPairs(input int n, input int stallAt, input int xFrom, output int used);
    int  cnt = 0;
    bit  stallDone = 0;
    used = 0;
    REQ_AB = 1;
    while (cnt < n && used < 60) begin
      if (cnt == stallAt && !stallDone) begin
        STALL = 1;
        repeat (4) begin
          X_VALID = (cnt >= xFrom); X = 16'h200 + 16'(used);
          #1; checkOutput("stallAck", ACK, 0);
          tick(); used++;
        end
        STALL = 0; stallDone = 1;
      end
      X_VALID = (cnt >= xFrom); X = 16'h200 + 16'(used);
      #1;
      if (ACK) begin
        checkOutput("pairA", A, 1);
        checkOutput("pairB", B, 32'(cnt + 1));
        cnt++;
      end
      tick(); used++;
    end
    REQ_AB = 0; X_VALID = 0;
    if (cnt < n) checkOutput("feedBound", cnt, n);
  endtask

  task automatic collect(input logic [15:0] base);
    int i = 0;
    while (BUSY && i < 20) begin
      X_VALID = 1; X = base + 16'(i);
      tick(); i++;
    end
    X_VALID = 0;
    checkOutput("collectEnds", BUSY, 0);
  endtask

  initial begin
    int used, c;
    tick(); tick();
    RST = 0;
    checkOutput("rstBusy", BUSY, 0);
    checkOutput("rstDone", DONE, 0);
    checkOutput("rstErr", ERR, 0);
    applyStimulus();

    $display("[TB] scenario 1: full run");
    launch();
    feedPairs(8, 99, 99, used);
`ifndef FEEDER_RAND_STALL_EN
    checkOutput("consecutive", used, 8);
`endif
    collect(16'h100);
    checkOutput("done1", DONE, 1);
    for (int i = 0; i < 8; i++) begin
      RD_ADDR = 3'(i); #1;
      checkOutput("rd1", RD_DATA, 32'(16'h100 + 16'(i)));
    end

    $display("[TB] scenario 2: stall after 7th pair, overlapped results");
`ifdef FEEDER_RAND_STALL_EN
    launch(); feedPairs(8, 7, 99, used);
`else
    launch(); feedPairs(8, 7, 7, used);
`endif
    collect(16'h300);
    checkOutput("done2", DONE, 1);

    $display("[TB] scenario 3: abort");
    launch(); feedPairs(3, 99, 99, used);
    ABORT = 1; tick(); ABORT = 0;
    checkOutput("haltAbort", HALT, 1);
    checkOutput("errAbort", ERR, 1);
    tick();
    checkOutput("haltOnce", HALT, 0);
    checkOutput("idleAfterHalt", BUSY, 0);
    GO = 1; tick(); GO = 0;
    checkOutput("restartA", A, 1);
    checkOutput("restartB", B, 1);
    ABORT = 1; tick(); ABORT = 0;
    checkOutput("haltAfterStart", HALT, 1);
    tick();

    $display("[TB] scenario 4: timeout");
    GO = 1; tick(); GO = 0;
    c = 0;
    while (!HALT && c < 200) begin tick(); c++; end
    checkOutput("timeoutCycles", c, 65);
    checkOutput("timeoutErr", ERR, 1);
    checkOutput("timeoutDone", DONE, 0);
    tick();

    $display("[TB] scenario 5: reset mid-run");
    launch(); feedPairs(8, 99, 99, used);
    for (int i = 0; i < 4; i++) begin
      X_VALID = 1; X = 16'h500 + 16'(i); tick();
    end
    X_VALID = 0; REQ_AB = 1; RST = 1; tick(); RST = 0;
    checkOutput("rstMidBusy", BUSY, 0);
    checkOutput("rstMidStart", START, 0);
    checkOutput("rstMidHalt", HALT, 0);
    checkOutput("rstMidAck", ACK, 0);
    repeat (5) begin tick(); checkOutput("noHaltAfterRst", HALT, 0); end
    REQ_AB = 0;
    for (int i = 0; i < 4; i++) begin
      RD_ADDR = 3'(i); #1;
      checkOutput("rdKept", RD_DATA, 32'(16'h500 + 16'(i)));
    end

`ifdef FEEDER_RAND_STALL_EN
    $display("[TB] scenario 6: random stall");
    launch(); feedPairs(8, 99, 99, used);
    collect(16'h600);
    checkOutput("done6", DONE, 1);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
